// File: rtl/seq_datapath.sv
// seq_datapath: multi-cycle register-file datapath.
// Each operation reads operand A, then operand B, runs the ALU and writes the
// result back. MOV and LDM skip the operand cycles and load C straight from
// the immediate or memory data.
module seq_datapath #(
  parameter  int WIDTH = 16,
  parameter  int NREG  = 8,
  localparam int RNW   = $clog2(NREG)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_op_valid,
  output logic             o_op_ready,
  input  logic [2:0]       i_op_code,
  input  logic [RNW-1:0]   i_rd,
  input  logic [RNW-1:0]   i_rn,
  input  logic [RNW-1:0]   i_rm,
  input  logic [1:0]       i_shift,
  input  logic             i_imm_sel,
  input  logic [WIDTH-1:0] i_imm,
  input  logic [WIDTH-1:0] i_mdata,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_N_out,
  output logic             o_V_out,
  output logic             o_Z_out
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOADA = 3'd1,
    LOADB = 3'd2,
    EXEC  = 3'd3,
    WB    = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    OP_MOV  = 3'b000,
    OP_ADD  = 3'b001,
    OP_SUB  = 3'b010,
    OP_AND  = 3'b011,
    OP_NOT  = 3'b100,
    OP_CMP  = 3'b101,
    OP_LDM  = 3'b110,
    OP_MOVR = 3'b111
  } opcode_t;

  state_t           r_state;
  state_t           w_nextState;

  opcode_t          r_op;
  logic [RNW-1:0]   r_rd;
  logic [RNW-1:0]   r_rn;
  logic [RNW-1:0]   r_rm;
  logic [1:0]       r_shift;
  logic             r_immSel;
  logic [WIDTH-1:0] r_imm;

  logic [WIDTH-1:0] r_A;
  logic [WIDTH-1:0] r_B;
  logic [WIDTH-1:0] r_C;
  logic             r_N;
  logic             r_V;
  logic             r_Z;
  logic [WIDTH-1:0] r_regs [NREG];

  logic             w_accept;
  logic             w_direct;
  logic [WIDTH-1:0] w_bShift;
  logic [WIDTH-1:0] w_bop;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_alu;
  logic             w_v;

  assign o_op_ready = (r_state == IDLE);
  assign o_done     = (r_state == WB);
  assign o_result   = r_C;
  assign o_N_out    = r_N;
  assign o_V_out    = r_V;
  assign o_Z_out    = r_Z;

  assign w_accept = i_op_valid && (r_state == IDLE);
  assign w_direct = (i_op_code == OP_MOV) || (i_op_code == OP_LDM);

  // State register; reset wins over any acceptance in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_nextState;
  end

  // Next-state logic: MOV/LDM jump straight to write-back, ALU ops walk all stages.
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE:    if (i_op_valid) w_nextState = w_direct ? WB : LOADA;
      LOADA:   w_nextState = LOADB;
      LOADB:   w_nextState = EXEC;
      EXEC:    w_nextState = WB;
      WB:      w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Capture the whole operation at acceptance so later input changes are harmless.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_op     <= OP_MOV;
      r_rd     <= '0;
      r_rn     <= '0;
      r_rm     <= '0;
      r_shift  <= '0;
      r_immSel <= 1'b0;
      r_imm    <= '0;
    end else if (w_accept) begin
      r_op     <= opcode_t'(i_op_code);
      r_rd     <= i_rd;
      r_rn     <= i_rn;
      r_rm     <= i_rm;
      r_shift  <= i_shift;
      r_immSel <= i_imm_sel;
      r_imm    <= i_imm;
    end
  end

  // B-operand shifter and ALU with overflow detection.
  always_comb begin
    w_bShift = r_B;
    unique case (r_shift)
      2'b00: w_bShift = r_B;
      2'b01: w_bShift = {r_B[WIDTH-2:0], 1'b0};
      2'b10: w_bShift = {1'b0, r_B[WIDTH-1:1]};
      2'b11: w_bShift = {r_B[WIDTH-1], r_B[WIDTH-1:1]};
      default: w_bShift = r_B;
    endcase
    w_bop  = r_immSel ? r_imm : w_bShift;
    w_sum  = r_A + w_bop;
    w_diff = r_A - w_bop;
    w_alu  = '0;
    w_v    = 1'b0;
    unique case (r_op)
      OP_ADD: begin
        w_alu = w_sum;
        w_v   = (r_A[WIDTH-1] == w_bop[WIDTH-1]) && (w_sum[WIDTH-1] != r_A[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        w_alu = w_diff;
        w_v   = (r_A[WIDTH-1] != w_bop[WIDTH-1]) && (w_diff[WIDTH-1] != r_A[WIDTH-1]);
      end
      OP_AND:  w_alu = r_A & w_bop;
      OP_NOT:  w_alu = ~w_bop;
      OP_MOVR: w_alu = w_bop;
      default: w_alu = '0;
    endcase
  end

  // Operand, result and flag registers; each loads only in its own stage.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_A <= '0;
      r_B <= '0;
      r_C <= '0;
      r_N <= 1'b0;
      r_V <= 1'b0;
      r_Z <= 1'b0;
    end else begin
      if (w_accept && (i_op_code == OP_MOV)) r_C <= i_imm;
      if (w_accept && (i_op_code == OP_LDM)) r_C <= i_mdata;
      if (r_state == LOADA) r_A <= r_regs[r_rn];
      if (r_state == LOADB) r_B <= r_regs[r_rm];
      if (r_state == EXEC) begin
        r_C <= w_alu;
        r_N <= w_alu[WIDTH-1];
        r_V <= w_v;
        r_Z <= (w_alu == '0);
      end
    end
  end

  // Register file: written from C on leaving WB, except for compares.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if ((r_state == WB) && (r_op != OP_CMP)) begin
      r_regs[r_rd] <= r_C;
    end
  end

endmodule

// File: tb/tb_seq_datapath.sv
// tb_seq_datapath: directed-vector bench for seq_datapath.
// A 16-bit/8-register instance carries the main sequence; an 8-bit/4-register
// instance shares the stimulus (low bits) and is checked for the narrow overflow case.
module tb_seq_datapath;

  localparam logic [2:0] OP_MOV  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_NOT  = 3'b100;
  localparam logic [2:0] OP_CMP  = 3'b101;
  localparam logic [2:0] OP_LDM  = 3'b110;
  localparam logic [2:0] OP_MOVR = 3'b111;

  logic        clock = 1'b0;
  logic        reset;
  logic        opValid;
  logic [2:0]  opCode;
  logic [2:0]  rdIdx;
  logic [2:0]  rnIdx;
  logic [2:0]  rmIdx;
  logic [1:0]  shiftSel;
  logic        immSel;
  logic [15:0] immVal;
  logic [15:0] mData;

  logic        opReady;
  logic        done;
  logic [15:0] result;
  logic        nOut;
  logic        vOut;
  logic        zOut;

  logic        opReady8;
  logic        done8;
  logic [7:0]  result8;
  logic        nOut8;
  logic        vOut8;
  logic        zOut8;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clock = ~clock;

  seq_datapath #(.WIDTH(16), .NREG(8)) dut (
    .i_clk      (clock),
    .i_reset    (reset),
    .i_op_valid (opValid),
    .o_op_ready (opReady),
    .i_op_code  (opCode),
    .i_rd       (rdIdx),
    .i_rn       (rnIdx),
    .i_rm       (rmIdx),
    .i_shift    (shiftSel),
    .i_imm_sel  (immSel),
    .i_imm      (immVal),
    .i_mdata    (mData),
    .o_done     (done),
    .o_result   (result),
    .o_N_out    (nOut),
    .o_V_out    (vOut),
    .o_Z_out    (zOut)
  );

  seq_datapath #(.WIDTH(8), .NREG(4)) dut8 (
    .i_clk      (clock),
    .i_reset    (reset),
    .i_op_valid (opValid),
    .o_op_ready (opReady8),
    .i_op_code  (opCode),
    .i_rd       (rdIdx[1:0]),
    .i_rn       (rnIdx[1:0]),
    .i_rm       (rmIdx[1:0]),
    .i_shift    (shiftSel),
    .i_imm_sel  (immSel),
    .i_imm      (immVal[7:0]),
    .i_mdata    (mData[7:0]),
    .o_done     (done8),
    .o_result   (result8),
    .o_N_out    (nOut8),
    .o_V_out    (vOut8),
    .o_Z_out    (zOut8)
  );

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Issue one operation, scramble the inputs after acceptance, wait for done
  // (bounded) and check latency, the done pulse width, result and NVZ.
  task automatic applyStimulus(input string tag, input logic [2:0] tOp,
                               input logic [2:0] tRd, input logic [2:0] tRn,
                               input logic [2:0] tRm, input logic [1:0] tShift,
                               input logic tImmSel, input logic [15:0] tImm,
                               input logic [15:0] tMdata,
                               input logic [15:0] expResult, input logic [2:0] expFlags);
    int lat;
    int expLat;
    expLat = ((tOp == OP_MOV) || (tOp == OP_LDM)) ? 1 : 4;
    @(negedge clock);
    checkOutput({tag, ".ready"}, 32'(opReady), 32'd1);
    opCode   = tOp;
    rdIdx    = tRd;
    rnIdx    = tRn;
    rmIdx    = tRm;
    shiftSel = tShift;
    immSel   = tImmSel;
    immVal   = tImm;
    mData    = tMdata;
    opValid  = 1'b1;
    @(posedge clock);
    #1;
    opValid  = 1'b0;
    opCode   = 3'($urandom);
    rdIdx    = 3'($urandom);
    rnIdx    = 3'($urandom);
    rmIdx    = 3'($urandom);
    shiftSel = 2'($urandom);
    immSel   = 1'($urandom);
    immVal   = ~tImm;
    mData    = ~tMdata;
    lat = 1;
    while ((done !== 1'b1) && (lat < 12)) begin
      @(posedge clock);
      #1;
      lat++;
    end
    checkOutput({tag, ".latency"}, 32'(lat), 32'(expLat));
    @(posedge clock);
    #1;
    checkOutput({tag, ".doneEnd"}, 32'(done), 32'd0);
    checkOutput({tag, ".result"}, 32'(result), 32'(expResult));
    checkOutput({tag, ".nvz"}, 32'({nOut, vOut, zOut}), 32'(expFlags));
  endtask

  // Directed sequence: every expected value below is worked out by hand.
  initial begin
    int cnt;
    logic sawDone;
    reset    = 1'b1;
    opValid  = 1'b0;
    opCode   = '0;
    rdIdx    = '0;
    rnIdx    = '0;
    rmIdx    = '0;
    shiftSel = '0;
    immSel   = 1'b0;
    immVal   = '0;
    mData    = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    checkOutput("reset.ready", 32'(opReady), 32'd1);
    checkOutput("reset.done", 32'(done), 32'd0);
    checkOutput("reset.result", 32'(result), 32'd0);
    checkOutput("reset.nvz", 32'({nOut, vOut, zOut}), 32'd0);

    // ADD with LSL1 on B: 2 + (7 << 1) = 16
    applyStimulus("movR0", OP_MOV, 3'd0, 3'd0, 3'd0, 2'b00, 1'b0, 16'd7, 16'h0, 16'd7, 3'b000);
    applyStimulus("movR1", OP_MOV, 3'd1, 3'd0, 3'd0, 2'b00, 1'b0, 16'd2, 16'h0, 16'd2, 3'b000);
    applyStimulus("addLsl", OP_ADD, 3'd2, 3'd1, 3'd0, 2'b01, 1'b0, 16'h0, 16'h0, 16'd16, 3'b000);
    applyStimulus("readR2", OP_MOVR, 3'd2, 3'd0, 3'd2, 2'b00, 1'b0, 16'h0, 16'h0, 16'd16, 3'b000);

    // SUB 69 - 420 = -351; MOV leaves the flags alone
    applyStimulus("movR3", OP_MOV, 3'd3, 3'd0, 3'd0, 2'b00, 1'b0, 16'd69, 16'h0, 16'd69, 3'b000);
    applyStimulus("movR4", OP_MOV, 3'd4, 3'd0, 3'd0, 2'b00, 1'b0, 16'd420, 16'h0, 16'd420, 3'b000);
    applyStimulus("sub", OP_SUB, 3'd5, 3'd3, 3'd4, 2'b00, 1'b0, 16'h0, 16'h0, 16'hFEA1, 3'b100);
    applyStimulus("movR6", OP_MOV, 3'd6, 3'd0, 3'd0, 2'b00, 1'b0, 16'h7FFF, 16'h0, 16'h7FFF, 3'b100);
    applyStimulus("movR7", OP_MOV, 3'd7, 3'd0, 3'd0, 2'b00, 1'b0, 16'hFFFF, 16'h0, 16'hFFFF, 3'b100);

    // CMP 0x7FFF - 0xFFFF overflows; no write, then LDM keeps the flags
    applyStimulus("cmp", OP_CMP, 3'd6, 3'd6, 3'd7, 2'b00, 1'b0, 16'h0, 16'h0, 16'h8000, 3'b110);
    applyStimulus("ldmZero", OP_LDM, 3'd0, 3'd0, 3'd0, 2'b00, 1'b0, 16'h0, 16'h0000, 16'h0000, 3'b110);
    applyStimulus("readR6", OP_MOVR, 3'd6, 3'd0, 3'd6, 2'b00, 1'b0, 16'h0, 16'h0, 16'h7FFF, 3'b000);
    applyStimulus("readR7", OP_MOVR, 3'd7, 3'd0, 3'd7, 2'b00, 1'b0, 16'h0, 16'h0, 16'hFFFF, 3'b100);

    // Shifter: ASR1 keeps the sign bit, LSR1 clears it
    applyStimulus("ldmR7", OP_LDM, 3'd7, 3'd0, 3'd0, 2'b00, 1'b0, 16'h0, 16'hEC0A, 16'hEC0A, 3'b100);
    applyStimulus("movrAsr", OP_MOVR, 3'd1, 3'd0, 3'd7, 2'b11, 1'b0, 16'h0, 16'h0, 16'hF605, 3'b100);
    applyStimulus("movrLsr", OP_MOVR, 3'd1, 3'd0, 3'd7, 2'b10, 1'b0, 16'h0, 16'h0, 16'h7605, 3'b000);

    // Immediate bypasses the shifter; NOT of all-ones gives zero
    applyStimulus("andImm", OP_AND, 3'd2, 3'd5, 3'd7, 2'b01, 1'b1, 16'd31, 16'h0, 16'h0001, 3'b000);
    applyStimulus("movR4b", OP_MOV, 3'd4, 3'd0, 3'd0, 2'b00, 1'b0, 16'hFFFF, 16'h0, 16'hFFFF, 3'b000);
    applyStimulus("not", OP_NOT, 3'd3, 3'd0, 3'd4, 2'b00, 1'b0, 16'h0, 16'h0, 16'h0000, 3'b001);

    // rd == rn == rm reads the old value; the next op sees the new one
    applyStimulus("movR0b", OP_MOV, 3'd0, 3'd0, 3'd0, 2'b00, 1'b0, 16'h7FFF, 16'h0, 16'h7FFF, 3'b001);
    applyStimulus("addSelf", OP_ADD, 3'd0, 3'd0, 3'd0, 2'b00, 1'b0, 16'h0, 16'h0, 16'hFFFE, 3'b110);
    applyStimulus("readR0", OP_MOVR, 3'd5, 3'd0, 3'd0, 2'b00, 1'b0, 16'h0, 16'h0, 16'hFFFE, 3'b100);

    // op_valid held high through the busy states must execute only once
    @(negedge clock);
    opCode   = OP_ADD;
    rdIdx    = 3'd3;
    rnIdx    = 3'd3;
    rmIdx    = 3'd6;
    shiftSel = 2'b00;
    immSel   = 1'b0;
    opValid  = 1'b1;
    cnt = 0;
    do begin
      @(negedge clock);
      cnt++;
    end while ((done !== 1'b1) && (cnt < 12));
    checkOutput("held.latency", 32'(cnt), 32'd4);
    opValid = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("held.ready", 32'(opReady), 32'd1);
    checkOutput("held.done", 32'(done), 32'd0);
    applyStimulus("heldRead", OP_MOVR, 3'd3, 3'd0, 3'd3, 2'b00, 1'b0, 16'h0, 16'h0, 16'h7FFF, 3'b000);

    // Reset in EXEC aborts the operation
    @(negedge clock);
    opCode   = OP_ADD;
    rdIdx    = 3'd2;
    rnIdx    = 3'd1;
    rmIdx    = 3'd0;
    shiftSel = 2'b01;
    immSel   = 1'b0;
    opValid  = 1'b1;
    @(posedge clock);
    #1;
    opValid = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("abort.done", 32'(done), 32'd0);
    checkOutput("abort.ready", 32'(opReady), 32'd1);
    checkOutput("abort.result", 32'(result), 32'd0);
    checkOutput("abort.nvz", 32'({nOut, vOut, zOut}), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    sawDone = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (done === 1'b1) sawDone = 1'b1;
    end
    checkOutput("abort.noDone", 32'(sawDone), 32'd0);
    applyStimulus("abortR2", OP_MOVR, 3'd2, 3'd0, 3'd2, 2'b00, 1'b0, 16'h0, 16'h0, 16'h0000, 3'b001);

    // Narrow instance: 0x7F + 1 overflows at 8 bits, not at 16
    applyStimulus("w8MovR0", OP_MOV, 3'd0, 3'd0, 3'd0, 2'b00, 1'b0, 16'h007F, 16'h0, 16'h007F, 3'b001);
    applyStimulus("w8MovR1", OP_MOV, 3'd1, 3'd0, 3'd0, 2'b00, 1'b0, 16'h0001, 16'h0, 16'h0001, 3'b001);
    applyStimulus("w8Add", OP_ADD, 3'd2, 3'd0, 3'd1, 2'b00, 1'b0, 16'h0, 16'h0, 16'h0080, 3'b000);
    checkOutput("w8.result", 32'(result8), 32'h80);
    checkOutput("w8.nvz", 32'({nOut8, vOut8, zOut8}), 32'b110);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/seq_datapath.md
SEQ_DATAPATH -- requirements
Module: seq_datapath

Interface
REQ-001 Parameters SHALL be as follows, one per line.
  - WIDTH, 16, data and register width in bits (>=4).
  - NREG, 8, register-file depth (power of two, >=2).
  - RNW, $clog2(NREG), register-index width (derived, not overridden).
REQ-002 Ports SHALL be as follows, one per line.
  - clk  in  1  single clock, all state updates on rising edge.
  - reset  in  1  synchronous, active-high reset.
  - op_valid  in  1  operation request.
  - op_ready  out  1  block can accept an operation.
  - op_code  in  3  operation select (REQ-006).
  - rd, rn, rm  in  RNW  destination index, operand-A index, operand-B index.
  - shift  in  2  B-operand shift: 00 none, 01 LSL1, 10 LSR1 (MSB<=0), 11 ASR1 (MSB kept).
  - imm_sel  in  1  1: B operand = imm, unshifted; 0: B operand = shifted R[rm].
  - imm  in  WIDTH  immediate, already sign-extended by the caller.
  - mdata  in  WIDTH  memory load data.
  - done  out  1  one-cycle completion pulse.
  - result  out  WIDTH  contents of result register C.
  - N_out, V_out, Z_out  out  1 each  status flags.

Function
REQ-003 op_ready SHALL be 1 exactly when the FSM is in IDLE; an operation is accepted on a rising edge where op_valid & op_ready.
REQ-004 At acceptance the block SHALL latch op_code, rd, rn, rm, shift, imm_sel, imm and mdata; later input changes SHALL NOT affect the operation.
REQ-005 FSM states SHALL be IDLE, LOADA, LOADB, EXEC and WB.
  - Transitions: IDLE->LOADA->LOADB->EXEC->WB->IDLE for ALU ops; IDLE->WB->IDLE for MOV/LDM.
REQ-006 op_code meanings SHALL be as follows.
  - 000 MOV: rd<=imm.
  - 001 ADD: rd<=A+B.
  - 010 SUB: rd<=A-B.
  - 011 AND: rd<=A&B.
  - 100 NOT: rd<=~B.
  - 101 CMP: A-B, flags only, no write.
  - 110 LDM: rd<=mdata.
  - 111 MOVR: rd<=B.
REQ-007 Datapath actions SHALL be as follows.
  - LOADA: A<=R[rn].
  - LOADB: B<=R[rm].
  - EXEC: C<=ALU(A, Bop) and flags updated, where Bop = imm if imm_sel else shift(B).
  - WB: R[rd]<=C unless op is CMP.
REQ-008 For MOV/LDM, C SHALL load imm/mdata at the acceptance edge, and flags SHALL be unchanged.
REQ-009 done SHALL be 1 only during the WB cycle: 4 cycles after acceptance for ALU ops, 1 cycle after acceptance for MOV/LDM.
REQ-010 Arithmetic SHALL be modulo 2^WIDTH with no carry output.
REQ-011 Flags SHALL be computed as follows.
  - N = C[WIDTH-1]; Z = (C==0).
  - V(ADD) = sign(A)==sign(Bop) and sign(C)!=sign(A).
  - V(SUB/CMP) = sign(A)!=sign(Bop) and sign(C)!=sign(A).
  - V = 0 for AND, NOT, MOVR.
REQ-012 A, B, C, the flags and all registers SHALL hold their value in every cycle without an explicit load in REQ-007/008.
REQ-013 op_valid while op_ready=0 SHALL be ignored and SHALL NOT be queued.
REQ-014 rd equal to rn or rm SHALL read the old value; the next operation, accepted no earlier than the cycle after WB, SHALL see the written value.
REQ-015 result SHALL equal C at all times, including during and after CMP.

Reset
REQ-016 On reset=1 at a rising edge, the following SHALL apply.
  - FSM<=IDLE; A, B, C<=0; all NREG registers<=0; {N,V,Z}<=000.
  - done=0 and op_ready=1 in the first cycle after the edge.
REQ-017 Reset during any non-IDLE state SHALL abort the operation: no register write, no done pulse.
REQ-018 Reset SHALL take priority over acceptance in the same cycle.

Verification (WIDTH=16, NREG=8 unless stated)
REQ-019 MOV R0,#7; MOV R1,#2; ADD R2,R1,R0 with shift=01 -> done 4 cycles after accept, result=16, NVZ=000, R2=16.
REQ-020 MOV R3,#69; MOV R4,#420; SUB R5,R3,R4 -> result=0xFEA1 (-351), NVZ=100; with R6=0x7FFF, R7=0xFFFF, CMP R6,R7 -> result=0x8000, NVZ=110, R6/R7 unchanged.
REQ-021 R7=0xEC0A, MOVR R1,R7 with shift=11 -> result=0xF605, NVZ=100; with shift=10 -> 0x7605, NVZ=000.
REQ-022 AND R2,R5,imm with imm_sel=1, imm=31, R5=0xFEA1 -> result=1, NVZ=000; NOT with B=0xFFFF -> result=0, NVZ=001.
REQ-023 Reset asserted in EXEC of ADD R2 -> no done pulse, op_ready=1 next cycle, R2 and result read 0, NVZ=000; op_valid held during busy states is not executed twice.
REQ-024 WIDTH=8, NREG=4: MOV R0,#0x7F; MOV R1,#1; ADD R2,R0,R1 -> result=0x80, NVZ=110.
